rr_mux4_arbiter: RTL and testbench

//   Round-robin arbiter and sequencer for a shared 4:1 single-bit mux datapath.

---
 rtl/rr_mux4_arbiter.sv | 110 +++++++++++
 tb/tb_rr_mux4_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/rr_mux4_arbiter.sv
// rr_mux4_arbiter
//   Round-robin arbiter and sequencer for a shared 4:1 single-bit mux.
//   One requester at a time owns the output line. The grant is held while the
//   requester keeps asserting req, for at most MAX_HOLD cycles. After every grant
//   there is one dead cycle so that the mux breaks before it makes.
// Ports
//   clk    : clock; all state changes on posedge
//   rst    : synchronous reset, active high
//   req[3:0]  : request lines, one per requester
//   in[3:0]   : data bit, one per requester
//   gnt[3:0]  : one-hot grant (registered); zero when nobody holds the grant
//   sel[1:0]  : mux select (registered); index of the current or last grantee
//   valid     : a grant is active (registered); always equal to |gnt
//   out       : in[sel] while valid, else 0 (combinational from in)
module rr_mux4_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] in,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       valid,
  output logic       out
);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         ptr_q,   ptr_d;
  logic [CNT_W-1:0]   hold_q,  hold_d;
  logic [3:0]         gnt_q,   gnt_d;
  logic [1:0]         sel_q,   sel_d;
  logic               valid_q, valid_d;

  // Rotating priority search: the first requester at or after ptr wins.
  // Scanning from the far end down lets the nearest match overwrite the rest.
  logic [1:0] win;
  logic       any_req;
  always_comb begin
    win     = ptr_q;
    any_req = |req;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr_q + 2'(k)]) win = ptr_q + 2'(k);
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE, RELEASE: begin
        // IDLE and RELEASE arbitrate identically; RELEASE exists only to force
        // the one-cycle gap, which falls out of leaving BUSY through it.
        if (any_req) begin
          gnt_d   = 4'b0001 << win;
          sel_d   = win;
          valid_d = 1'b1;
          hold_d  = CNT_W'(1);
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (req[sel_q] && (hold_q < CNT_W'(MAX_HOLD))) begin
          hold_d = hold_q + CNT_W'(1);
        end else begin
          // sel keeps its value; the rotation restarts just past the last owner.
          gnt_d   = 4'b0000;
          valid_d = 1'b0;
          hold_d  = '0;
          ptr_d   = sel_q + 2'd1;
          state_d = RELEASE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      hold_q  <= '0;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign valid = valid_q;
  assign out   = valid_q ? in[sel_q] : 1'b0;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Bench for rr_mux4_arbiter: directed scenarios followed by random traffic, all
// compared every cycle against an ownership-level model of the arbiter.
module tb_rr_mux4_arbiter;
  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, din;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valid, dout;

  rr_mux4_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .in(din),
    .gnt(gnt), .sel(sel), .valid(valid), .out(dout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit armed   = 1'b0;

  // Model: who owns the line (-1 = nobody), how long it has owned it,
  // where the rotation starts, and the last index handed out.
  int m_own  = -1;
  int m_held = 0;
  int m_ptr  = 0;
  int m_sel  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input logic [3:0] rq);
    if (r) begin
      m_own = -1; m_held = 0; m_ptr = 0; m_sel = 0;
    end else if (m_own >= 0) begin
      if (!rq[m_own] || m_held == MAX_HOLD) begin
        m_ptr = (m_own + 1) % 4;
        m_own = -1;
      end else begin
        m_held++;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (rq[(m_ptr + k) % 4]) begin
          m_own = (m_ptr + k) % 4;
          m_sel = m_own;
          m_held = 1;
          break;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [3:0] eg;
    logic       eo;
    eg = (m_own >= 0) ? (4'b0001 << m_own) : 4'b0000;
    eo = (m_own >= 0) ? din[m_sel] : 1'b0;
    chk("gnt",   32'(gnt),   32'(eg));
    chk("sel",   32'(sel),   32'(m_sel));
    chk("valid", 32'(valid), 32'(m_own >= 0));
    chk("out",   32'(dout),  32'(eo));
  endtask

  // Drive on the falling edge, check state plus the combinational out with the
  // new data, then advance the model on the rising edge with the same inputs.
  task automatic cycle(input bit r, input logic [3:0] rq, input logic [3:0] d);
    @(negedge clk);
    rst = r; req = rq; din = d;
    #1;
    if (armed) check_outputs();
    @(posedge clk);
    model_step(r, rq);
    if (r) armed = 1'b1;
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; din = 4'b0000;

    // T1: reset with everything asserted, then first grant one clock later
    cycle(1, 4'b1111, 4'b1111);
    cycle(1, 4'b1111, 4'b1111);
    #1 chk("t1_gnt_rst", 32'(gnt), 32'h0);
    cycle(0, 4'b1111, 4'b1111);
    #1 chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_out", 32'(dout), 32'h1);

    // T2: all requesting, full rotation with gaps and wrap back to 0
    cycle(1, 4'b1111, 4'b0000);
    for (int i = 1; i <= 37; i++) begin
      cycle(0, 4'b1111, 4'($urandom));
      if (i == 8)  #1 chk("t2_hold8", 32'(gnt), 32'h1);
      if (i == 9)  #1 chk("t2_gap", 32'(gnt), 32'h0);
      if (i == 10) #1 chk("t2_next", 32'(gnt), 32'h2);
      if (i == 37) #1 chk("t2_wrap", 32'(gnt), 32'h1);
    end

    // T3: short grant to 2, drop, then ptr=3 makes requester 0 win over 2
    cycle(1, 4'b0000, 4'b0100);
    for (int i = 0; i < 3; i++) cycle(0, 4'b0100, 4'b0100);
    #1 chk("t3_sel", 32'(sel), 32'h2);
    cycle(0, 4'b0000, 4'b0100);
    #1 chk("t3_rel", 32'(gnt), 32'h0);
    cycle(0, 4'b0000, 4'b0100);
    cycle(0, 4'b0101, 4'b0100);
    #1 chk("t3_ptr3", 32'(gnt), 32'h1);

    // T4: lone requester held: 8 on, 1 off, repeat
    cycle(1, 4'b0000, 4'b0000);
    for (int i = 0; i < 20; i++) begin
      cycle(0, 4'b0010, 4'($urandom));
      #1 chk("t4_vld", 32'(valid), 32'(|gnt));
    end

    // T5: reset mid-grant, then rotation restarts at 0
    cycle(1, 4'b0000, 4'b0000);
    for (int i = 0; i < 4; i++) cycle(0, 4'b0100, 4'b1111);
    cycle(1, 4'b1111, 4'b1111);
    #1 chk("t5_gnt", 32'(gnt), 32'h0);
    chk("t5_sel", 32'(sel), 32'h0);
    cycle(0, 4'b1111, 4'b1111);
    #1 chk("t5_first", 32'(gnt), 32'h1);

    // T6: out follows in[3] within the cycle, and is 0 during the gap
    cycle(1, 4'b0000, 4'b0000);
    cycle(0, 4'b1000, 4'b1001);
    cycle(0, 4'b1000, 4'b1001);
    cycle(0, 4'b1000, 4'b0001);
    cycle(0, 4'b0000, 4'b0001);
    cycle(0, 4'b0000, 4'b1111);

    // Random traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] rq;
      rq = 4'($urandom) & 4'($urandom | ($urandom_range(0, 1) ? 32'hF : 32'h0));
      cycle($urandom_range(0, 99) == 0, rq, 4'($urandom));
    end
    cycle(0, 4'b0000, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
